// File: rtl/prng_word_buffer.sv
// prng_word_buffer
// Takes the generator's two output words each enabled cycle, throws away a
// warm-up window after every restart, whitens the pair (in_a ^ in_b) and
// queues the result in a small first-word-fall-through FIFO presented as a
// valid/ready stream. Words that arrive while the FIFO is full are dropped
// and counted.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | en low (or out of reset); inputs ignored, warm counter cleared
// WARM  | en high, still inside the warm-up window; words are discarded
// RUN   | en high, warm-up done; every enabled cycle writes one word
//
// The en cycle that leaves IDLE is always discarded and counts as the first
// warm-up cycle, so WARMUP=N discards exactly N cycles for N>=1. For
// WARMUP<=1 that single transition cycle already covers the window, so IDLE
// moves straight to RUN and one cycle is discarded.

module prng_word_buffer #(
  parameter int DEPTH  = 8,
  parameter int WARMUP = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [31:0]              in_a_i,
  input  logic [31:0]              in_b_i,
  input  logic                     clr_i,
  output logic [31:0]              out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              drop_count_o,
  output logic                     overflow_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int WCW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP);
  localparam logic [LW-1:0]  LVL_FULL  = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   warm_cnt_q, warm_cnt_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  logic [31:0]      mem_q [DEPTH];

  logic             fifo_empty;
  logic             fifo_full;
  logic             write;
  logic             pop;
  logic             push;
  logic             drop;
  logic [31:0]      wdata;

  // Warm-up sequencing: decides state and whether this cycle's words are kept
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        warm_cnt_d = '0;
        if (en_i) begin
          if (WARMUP <= 1) begin
            state_d = ST_RUN;
          end else begin
            state_d    = ST_WARM;
            warm_cnt_d = WCW'(1);
          end
        end
      end
      ST_WARM: begin
        if (!en_i) begin
          state_d    = ST_IDLE;
          warm_cnt_d = '0;
        end else if (warm_cnt_q + WCW'(1) == WARM_LAST) begin
          state_d    = ST_RUN;
          warm_cnt_d = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + WCW'(1);
        end
      end
      ST_RUN: begin
        warm_cnt_d = '0;
        if (!en_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        warm_cnt_d = '0;
      end
    endcase
  end

  // FSM state and warm counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Handshake decode; the write path only ever sees data when en is high
  always_comb begin
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_FULL);
    write      = (state_q == ST_RUN) && en_i;
    pop        = !fifo_empty && out_ready_i;
    push       = write && (!fifo_full || pop);
    drop       = write && fifo_full && !pop;
    wdata      = write ? (in_a_i ^ in_b_i) : 32'h0;
  end

  // Pointer/level bookkeeping and the registered head word
  always_comb begin
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    level_d    = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    out_data_d = out_data_q;
    if (level_d != '0) begin
      // With one entry left after this cycle and a write happening, that
      // entry must be the word being written now (memory not yet updated).
      if (push && (level_d == LW'(1))) begin
        out_data_d = wdata;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  // FIFO control registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Drop statistics; clear takes priority over a same-cycle drop
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (clr_i) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // Drop statistics registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = !fifo_empty;
  assign level_o      = level_q;
  assign drop_count_o = drop_cnt_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_prng_word_buffer.sv
// Bench for prng_word_buffer: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.

module tb_prng_word_buffer;

  localparam int DEPTH   = 8;
  localparam int WARMUP  = 4;
  localparam int WARMUP2 = 2;

  logic        clk;
  logic        rst;
  logic        en, clr, ready;
  logic [31:0] in_a, in_b;
  logic [31:0] out_data;
  logic        out_valid;
  logic [3:0]  level;
  logic [15:0] drop_count;
  logic        overflow;

  logic        en2, ready2;
  logic [31:0] in_a2, in_b2;
  logic [31:0] out_data2;
  logic        out_valid2;
  logic [3:0]  level2;
  logic [15:0] drop_count2;
  logic        overflow2;

  int checks   = 0;
  int failures = 0;

  prng_word_buffer #(.DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .in_a_i(in_a), .in_b_i(in_b),
    .clr_i(clr), .out_data_o(out_data), .out_valid_o(out_valid),
    .out_ready_i(ready), .level_o(level), .drop_count_o(drop_count),
    .overflow_o(overflow)
  );

  prng_word_buffer #(.DEPTH(DEPTH), .WARMUP(WARMUP2)) dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(en2), .in_a_i(in_a2), .in_b_i(in_b2),
    .clr_i(1'b0), .out_data_o(out_data2), .out_valid_o(out_valid2),
    .out_ready_i(ready2), .level_o(level2), .drop_count_o(drop_count2),
    .overflow_o(overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: run length of consecutive en cycles decides which words
  // are kept; the FIFO itself is a plain queue.
  logic [31:0] mq[$];
  int          m_run;
  logic [31:0] m_data;
  int          m_drop;
  bit          m_ovf;

  function automatic void model_reset();
    mq.delete();
    m_run  = 0;
    m_data = 32'h0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_step(bit e, logic [31:0] a, logic [31:0] b, bit r, bit c);
    bit wr;
    int keep_after;
    keep_after = (WARMUP < 1) ? 1 : WARMUP;
    wr = 1'b0;
    if (e) begin
      m_run++;
      wr = (m_run > keep_after);
    end else begin
      m_run = 0;
    end
    if (mq.size() > 0 && r) void'(mq.pop_front());
    if (wr) begin
      if (mq.size() < DEPTH) mq.push_back(a ^ b);
      else if (!c) begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (c) begin
      m_drop = 0;
      m_ovf  = 1'b0;
    end
    if (mq.size() > 0) m_data = mq[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_valid", {31'h0, out_valid}, {31'h0, (mq.size() > 0)});
    chk("m_level", {28'h0, level}, mq.size());
    chk("m_data", out_data, m_data);
    chk("m_drop", {16'h0, drop_count}, m_drop);
    chk("m_ovf", {31'h0, overflow}, {31'h0, m_ovf});
  endtask

  task automatic step(input bit e, input logic [31:0] a, input logic [31:0] b,
                      input bit r, input bit c);
    en = e; in_a = a; in_b = b; ready = r; clr = c;
    @(posedge clk); #1;
    model_step(e, a, b, r, c);
    check_model();
  endtask

  task automatic step2(input bit e, input logic [31:0] a, input bit r);
    en2 = e; in_a2 = a; in_b2 = 32'h5; ready2 = r;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          en;
    logic [31:0] a;
    logic [31:0] b;
    bit          ready;
    bit          exp_valid;
    int          exp_level;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] popped;
    logic [31:0] first3;

    tbl[0] = '{1'b1, 32'h1, 32'h3, 1'b0, 1'b0, 0, 32'h0};
    tbl[1] = '{1'b1, 32'h1, 32'h3, 1'b0, 1'b0, 0, 32'h0};
    tbl[2] = '{1'b1, 32'h1, 32'h3, 1'b0, 1'b0, 0, 32'h0};
    tbl[3] = '{1'b1, 32'h1, 32'h3, 1'b0, 1'b0, 0, 32'h0};
    tbl[4] = '{1'b1, 32'h1, 32'h3, 1'b0, 1'b1, 1, 32'h2};
    tbl[5] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1, 32'h2};
    tbl[6] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 32'h2};

    rst = 1'b1; en = 0; clr = 0; ready = 0; in_a = 0; in_b = 0;
    en2 = 0; ready2 = 0; in_a2 = 0; in_b2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_level", {28'h0, level}, 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_drop", {16'h0, drop_count}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);

    // Warm-up and first write latency
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].en, tbl[i].a, tbl[i].b, tbl[i].ready, 1'b0);
      chk($sformatf("tbl%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_level", i), {28'h0, level}, tbl[i].exp_level);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
    end

    // Fill to full, then overflow by three
    for (int i = 0; i < WARMUP; i++) step(1'b1, 32'hDEAD0000, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 32'h100 + i, 32'h0, 1'b0, 1'b0);
    chk("full_level", {28'h0, level}, 32'd8);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + i, 32'h0, 1'b0, 1'b0);
    chk("ovf_drop", {16'h0, drop_count}, 32'd3);
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
    chk("ovf_head", out_data, 32'h100);

    // Full with simultaneous write and pop, across pointer wrap
    for (int i = 0; i < 10; i++) begin
      popped = out_data;
      chk($sformatf("wrap_pop%0d", i), popped, (i < 8) ? (32'h100 + i) : (32'h200 + i - 8));
      step(1'b1, 32'h200 + i, 32'h0, 1'b1, 1'b0);
      chk($sformatf("wrap_level%0d", i), {28'h0, level}, 32'd8);
      chk($sformatf("wrap_drop%0d", i), {16'h0, drop_count}, 32'd3);
    end

    // Saturation from a forced near-max count, then clear against a drop
    force dut.drop_cnt_q = 16'hFFFE;
    #1 release dut.drop_cnt_q;
    m_drop = 16'hFFFE;
    chk("force_drop", {16'h0, drop_count}, 32'hFFFE);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + i, 32'h0, 1'b0, 1'b0);
    chk("sat_drop", {16'h0, drop_count}, 32'hFFFF);
    chk("sat_ovf", {31'h0, overflow}, 32'h1);
    step(1'b1, 32'h500, 32'h0, 1'b0, 1'b1);
    chk("clr_drop", {16'h0, drop_count}, 32'h0);
    chk("clr_ovf", {31'h0, overflow}, 32'h0);
    chk("clr_level", {28'h0, level}, 32'd8);
    step(1'b1, 32'h501, 32'h0, 1'b0, 1'b0);
    chk("redrop", {16'h0, drop_count}, 32'h1);

    // Async reset with level 5 and valid high
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pre_rst_level", {28'h0, level}, 32'd5);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_level", {28'h0, level}, 32'h0);
    chk("arst_data", out_data, 32'h0);
    chk("arst_drop", {16'h0, drop_count}, 32'h0);
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < WARMUP; i++) step(1'b1, 32'h7, 32'h1, 1'b0, 1'b0);
    chk("rewarm_level", {28'h0, level}, 32'h0);
    step(1'b1, 32'h7, 32'h1, 1'b0, 1'b0);
    chk("rewarm_write", {28'h0, level}, 32'h1);
    chk("rewarm_data", out_data, 32'h6);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 99) < 85, $urandom, $urandom,
           bit'($urandom_range(0, 1)), $urandom_range(0, 99) < 3);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Re-warm after an en gap on the WARMUP=2 instance; contents survive IDLE
    step2(1'b1, 32'h10, 1'b0);
    step2(1'b1, 32'h11, 1'b0);
    chk("w2_discard", {28'h0, level2}, 32'h0);
    step2(1'b1, 32'h12, 1'b0);
    chk("w2_first", {28'h0, level2}, 32'h1);
    first3 = 32'h12 ^ 32'h5;
    chk("w2_first_data", out_data2, first3);
    step2(1'b0, 32'h13, 1'b0);
    chk("w2_idle_keep", {28'h0, level2}, 32'h1);
    step2(1'b1, 32'h14, 1'b0);
    step2(1'b1, 32'h15, 1'b0);
    chk("w2_rewarm", {28'h0, level2}, 32'h1);
    step2(1'b1, 32'h16, 1'b0);
    chk("w2_second", {28'h0, level2}, 32'h2);
    step2(1'b0, 32'h0, 1'b1);
    chk("w2_pop1_data", out_data2, 32'h16 ^ 32'h5);
    step2(1'b0, 32'h0, 1'b1);
    chk("w2_empty", {31'h0, out_valid2}, 32'h0);
    chk("w2_drop", {16'h0, drop_count2}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
